// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } state_e;

endpackage

// File: rtl/wait_timer.sv
// Saturating wait-cycle counter; expired_c flags the cycle whose count would reach TIMEOUT.
module wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_W'(TIMEOUT))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires during the TIMEOUT-th consecutive unacked cycle so the error lands one edge later.
    assign expired_c = en_i && !clear_i && (count_q >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: reads one byte per instruction, holds it for decode, steers the PC.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_step,
    output logic              pc_set,
    output logic [ADDR_W-1:0] pc_set_val,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              err
);

    state_e            state_q,      state_d;
    logic              pc_step_q,    pc_step_d;
    logic              pc_set_q,     pc_set_d;
    logic [ADDR_W-1:0] pc_set_val_q, pc_set_val_d;
    logic [DATA_W-1:0] instr_data_q, instr_data_d;
    logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
    logic              err_q,        err_d;

    logic              in_fetch_c;
    logic              expired_c;
    logic [ADDR_W-1:0] fetch_addr_c;

    assign in_fetch_c = (state_q == FETCH);

    // The counter loads one edge after pc_set, so forward the pending target meanwhile.
    assign fetch_addr_c = pc_set_q ? pc_set_val_q : pc_in;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (!in_fetch_c || redirect),
        .en_i      (in_fetch_c && !mem_ack),
        .expired_c (expired_c)
    );

    always_comb begin
        state_d      = state_q;
        pc_step_d    = 1'b0;
        pc_set_d     = 1'b0;
        pc_set_val_d = pc_set_val_q;
        instr_data_d = instr_data_q;
        instr_addr_d = instr_addr_q;
        err_d        = err_q;

        if (state_q == ERR) begin
            state_d = ERR;
        end else if (redirect) begin
            pc_set_d     = 1'b1;
            pc_set_val_d = redirect_addr;
            state_d      = run ? FETCH : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        instr_data_d = mem_rdata;
                        instr_addr_d = fetch_addr_c;
                        pc_step_d    = 1'b1;
                        state_d      = VALID;
                    end else if (expired_c) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        state_d = run ? FETCH : IDLE;
                    end
                end
                default: state_d = ERR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_step_q    <= 1'b0;
            pc_set_q     <= 1'b0;
            pc_set_val_q <= '0;
            instr_data_q <= '0;
            instr_addr_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_step_q    <= pc_step_d;
            pc_set_q     <= pc_set_d;
            pc_set_val_q <= pc_set_val_d;
            instr_data_q <= instr_data_d;
            instr_addr_q <= instr_addr_d;
            err_q        <= err_d;
        end
    end

    assign mem_req     = in_fetch_c;
    assign mem_addr    = in_fetch_c ? fetch_addr_c : '0;
    assign instr_valid = (state_q == VALID);
    assign pc_step     = pc_step_q;
    assign pc_set      = pc_set_q;
    assign pc_set_val  = pc_set_val_q;
    assign instr_data  = instr_data_q;
    assign instr_addr  = instr_addr_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural program counter upstream.
module tb_fetch_sequencer;

    logic       clk;
    logic       reset_n;
    logic       run;
    logic [7:0] pc_in;
    logic       pc_step;
    logic       pc_set;
    logic [7:0] pc_set_val;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_data;
    logic [7:0] instr_addr;
    logic       redirect;
    logic [7:0] redirect_addr;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    fetch_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run           (run),
        .pc_in         (pc_in),
        .pc_step       (pc_step),
        .pc_set        (pc_set),
        .pc_set_val    (pc_set_val),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_addr    (instr_addr),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream program counter: load wins over step, wraps naturally at 8 bits.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)      pc_in <= 8'h00;
        else if (pc_set)   pc_in <= pc_set_val;
        else if (pc_step)  pc_in <= pc_in + 8'h01;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset_n       = 1'b0;
        run           = 1'b0;
        mem_ack       = 1'b0;
        mem_rdata     = 8'h00;
        instr_ready   = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 8'h00;
        tick();
        tick();
        check_eq("rst_req",   32'(mem_req),     32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'h0);
        check_eq("rst_err",   32'(err),         32'h0);
        check_eq("rst_step",  32'(pc_step),     32'h0);
        check_eq("rst_set",   32'(pc_set),      32'h0);
        check_eq("rst_data",  32'(instr_data),  32'h0);
        check_eq("rst_addr",  32'(mem_addr),    32'h0);
        reset_n = 1'b1;
        tick();

        // Zero-wait fetch of 0x3C at pc 0x00.
        run = 1'b1;
        tick();
        check_eq("t1_req",  32'(mem_req),  32'h1);
        check_eq("t1_addr", 32'(mem_addr), 32'h00);
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        tick();
        mem_ack = 1'b0;
        check_eq("t1_valid", 32'(instr_valid), 32'h1);
        check_eq("t1_data",  32'(instr_data),  32'h3C);
        check_eq("t1_iaddr", 32'(instr_addr),  32'h00);
        check_eq("t1_step",  32'(pc_step),     32'h1);
        check_eq("t1_noreq", 32'(mem_req),     32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("t1_next_req",  32'(mem_req),     32'h1);
        check_eq("t1_next_addr", 32'(mem_addr),    32'h01);
        check_eq("t1_step_off",  32'(pc_step),     32'h0);
        check_eq("t1_valid_off", 32'(instr_valid), 32'h0);

        // Three wait cycles before ack, then decode stalls four cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t2_wait_req", 32'(mem_req), 32'h1);
        end
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        tick();
        mem_ack = 1'b0;
        check_eq("t2_step", 32'(pc_step), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_hold_valid", 32'(instr_valid), 32'h1);
            check_eq("t2_hold_data",  32'(instr_data),  32'h5A);
            check_eq("t2_hold_iaddr", 32'(instr_addr),  32'h01);
            check_eq("t2_hold_noreq", 32'(mem_req),     32'h0);
            tick();
        end
        check_eq("t2_step_once", 32'(pc_step), 32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("t2_next_addr", 32'(mem_addr), 32'h02);

        // Redirect to 0xA0 colliding with an ack: data dropped, no step.
        mem_ack = 1'b1; mem_rdata = 8'h77;
        redirect = 1'b1; redirect_addr = 8'hA0;
        tick();
        mem_ack = 1'b0; redirect = 1'b0;
        check_eq("t3_set",     32'(pc_set),      32'h1);
        check_eq("t3_set_val", 32'(pc_set_val),  32'hA0);
        check_eq("t3_nostep",  32'(pc_step),     32'h0);
        check_eq("t3_novalid", 32'(instr_valid), 32'h0);
        check_eq("t3_keep",    32'(instr_data),  32'h5A);
        check_eq("t3_req",     32'(mem_req),     32'h1);
        check_eq("t3_addr",    32'(mem_addr),    32'hA0);
        mem_ack = 1'b1; mem_rdata = 8'h11;
        tick();
        mem_ack = 1'b0;
        check_eq("t3_data",  32'(instr_data), 32'h11);
        check_eq("t3_iaddr", 32'(instr_addr), 32'hA0);
        check_eq("t3_step",  32'(pc_step),    32'h1);
        check_eq("t3_set0",  32'(pc_set),     32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("t3_next_addr", 32'(mem_addr), 32'hA1);

        // Branch to 0xFF then step across the wrap.
        redirect = 1'b1; redirect_addr = 8'hFF;
        tick();
        redirect = 1'b0;
        check_eq("t4_addr_ff", 32'(mem_addr), 32'hFF);
        mem_ack = 1'b1; mem_rdata = 8'h99;
        tick();
        mem_ack = 1'b0;
        check_eq("t4_iaddr", 32'(instr_addr), 32'hFF);
        check_eq("t4_step",  32'(pc_step),    32'h1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("t4_wrap_addr", 32'(mem_addr), 32'h00);
        check_eq("t4_wrap_req",  32'(mem_req),  32'h1);

        // Run drops in FETCH: instruction still delivered, then idle.
        run = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h42;
        tick();
        mem_ack = 1'b0;
        check_eq("t5_valid", 32'(instr_valid), 32'h1);
        check_eq("t5_data",  32'(instr_data),  32'h42);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("t5_idle_req",   32'(mem_req),     32'h0);
        check_eq("t5_idle_valid", 32'(instr_valid), 32'h0);

        // Stray ack while idle is ignored.
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        tick();
        mem_ack = 1'b0;
        check_eq("t5_stray_data",  32'(instr_data),  32'h42);
        check_eq("t5_stray_valid", 32'(instr_valid), 32'h0);
        check_eq("t5_stray_step",  32'(pc_step),     32'h0);

        // Redirect while idle with run low.
        redirect = 1'b1; redirect_addr = 8'h10;
        tick();
        redirect = 1'b0;
        check_eq("t6_set",     32'(pc_set),     32'h1);
        check_eq("t6_set_val", 32'(pc_set_val), 32'h10);
        check_eq("t6_idle",    32'(mem_req),    32'h0);

        // Timeout: 15 unacked FETCH cycles, then ERR.
        run = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_eq("t6_to_req", 32'(mem_req), 32'h1);
            check_eq("t6_to_err", 32'(err),     32'h0);
            if (i == 0) check_eq("t6_to_addr", 32'(mem_addr), 32'h10);
        end
        tick();
        check_eq("t6_err",     32'(err),     32'h1);
        check_eq("t6_err_req", 32'(mem_req), 32'h0);
        redirect = 1'b1; redirect_addr = 8'h55; mem_ack = 1'b1;
        tick();
        tick();
        redirect = 1'b0; mem_ack = 1'b0;
        check_eq("t6_sticky_err", 32'(err),         32'h1);
        check_eq("t6_sticky_set", 32'(pc_set),      32'h0);
        check_eq("t6_sticky_req", 32'(mem_req),     32'h0);
        check_eq("t6_sticky_val", 32'(instr_valid), 32'h0);

        // Only reset clears the error.
        reset_n = 1'b0;
        #1;
        check_eq("t7_err_clr", 32'(err), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Async reset in the middle of a VALID cycle.
        tick();
        check_eq("t7_req", 32'(mem_req), 32'h1);
        mem_ack = 1'b1; mem_rdata = 8'hC3;
        tick();
        mem_ack = 1'b0;
        check_eq("t7_valid", 32'(instr_valid), 32'h1);
        check_eq("t7_data",  32'(instr_data),  32'hC3);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t7_rst_valid", 32'(instr_valid), 32'h0);
        check_eq("t7_rst_data",  32'(instr_data),  32'h0);
        check_eq("t7_rst_step",  32'(pc_step),     32'h0);
        check_eq("t7_rst_req",   32'(mem_req),     32'h0);
        check_eq("t7_rst_iaddr", 32'(instr_addr),  32'h0);
        tick();
        run = 1'b0;
        reset_n = 1'b1;
        tick();
        check_eq("t7_idle_req",   32'(mem_req),     32'h0);
        check_eq("t7_idle_valid", 32'(instr_valid), 32'h0);
        run = 1'b1;
        tick();
        check_eq("t7_restart_req",  32'(mem_req),  32'h1);
        check_eq("t7_restart_addr", 32'(mem_addr), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch control stage sitting directly downstream of the 8-bit program `counter`. It consumes the counter's `out` value as the fetch address and issues one memory read per instruction over a req/ack handshake. It latches the returned byte into an instruction register and presents it to decode with valid/ready. It also drives the counter's advance and set/load controls, which handle sequential stepping and branch redirects.

## Interface
- `ADDR_W`, 8: address width; matches the counter width.
- `DATA_W`, 8: instruction width.
- `TIMEOUT`, 15: maximum cycles `FETCH` waits for `mem_ack` before error; must be ≥1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  enables fetching; sampled in `IDLE` and at instruction hand-off.
- `pc_in`  in  ADDR_W  current counter `out`.
- `pc_step`  out  1  one-cycle pulse; the counter advances by one.
- `pc_set`  out  1  one-cycle pulse; the counter loads `pc_set_val` (drives counter `set`).
- `pc_set_val`  out  ADDR_W  load value (drives counter `in`).
- `mem_req`  out  1  read request.
- `mem_addr`  out  ADDR_W  read address.
- `mem_ack`  in  1  read data valid this cycle.
- `mem_rdata`  in  DATA_W  read data.
- `instr_valid`  out  1  `instr_data` is valid.
- `instr_ready`  in  1  decode accepts the instruction.
- `instr_data`  out  DATA_W  instruction register.
- `instr_addr`  out  ADDR_W  address the instruction was fetched from.
- `redirect`  in  1  branch/jump request, single-cycle.
- `redirect_addr`  in  ADDR_W  branch target.
- `err`  out  1  sticky fetch-timeout flag.

## Operation
- States: `IDLE`, `FETCH`, `VALID`, `ERR`.
- Reset (async, `reset_n`=0):
  - state goes to `IDLE`.
  - All outputs and the instruction register, address register and wait counter are cleared to 0.
- `IDLE`: goes to `FETCH` when `run`=1.
- `FETCH`:
  - Outputs: `mem_req`=1, `mem_addr`=`pc_in` (combinational).
  - On `mem_ack`=1: capture `instr_data`←`mem_rdata` and `instr_addr`←`pc_in`, pulse `pc_step`, go to `VALID`.
  - Wait counter: increments on each `FETCH` cycle with `mem_ack`=0 and clears on entering `FETCH`.
  - Timeout: when the count reaches `TIMEOUT`, set `err`=1 and go to `ERR`.
- `VALID`:
  - Output: `instr_valid`=1.
  - On `instr_ready`=1: go to `FETCH` if `run`=1, else `IDLE`.
- `ERR`: `mem_req`=0 and `instr_valid`=0. The state persists and ignores `run`/`redirect`; only reset exits.
- `redirect`=1 in `IDLE`, `FETCH` or `VALID`:
  - Pulses `pc_set` with `pc_set_val`=`redirect_addr`.
  - Drops any in-flight fetch (ack data in that cycle discarded, no `pc_step`).
  - Clears `instr_valid`.
  - Next state is `FETCH` if `run`=1, else `IDLE`.
- Priority (highest first): reset, then `ERR`, then `redirect`, then `mem_ack`, then timeout.
- `redirect` and `instr_ready` in the same `VALID` cycle: the handshake counts as completed and the redirect still applies.
- `run` dropping during `FETCH`: the outstanding request completes; the instruction is delivered; then `IDLE`.
- `mem_ack` outside `FETCH` is ignored.
- Wrap-around of `pc_in` (0xFF→0x00) is handled by the counter; this block passes addresses unmodified.
- `pc_step` and `pc_set` are never asserted in the same cycle.

## Timing
- `mem_req` is high in the first cycle of `FETCH`. A same-cycle `mem_ack` gives the minimum of 2 cycles per instruction (`FETCH`, `VALID` with `instr_ready`=1).
- `instr_valid` rises one cycle after the acked `FETCH` cycle.
- Counter effects are seen on `pc_in` one edge after the pulse:
  - after `pc_step`, `pc_in` shows the incremented value in the next `FETCH`;
  - after `pc_set`, `pc_in` = target in the next `FETCH` cycle.
- Timeout: `err` rises the cycle after the `TIMEOUT`-th consecutive unacked `FETCH` cycle.
- All outputs are registered except `mem_addr` and the combinational decode of `mem_req`/`instr_valid` from state.

## Structure
- `fetch_pkg` holds:
  - the state enum (`IDLE`, `FETCH`, `VALID`, `ERR`);
  - default `ADDR_W`/`DATA_W`;
  - the `TIMEOUT` default.
- One sub-module: `wait_timer` (saturating cycle counter with clear/enable and a `expired` flag at `TIMEOUT`).

## Test plan
- Reset then `run`=1, memory returns 0x3C with 0-wait ack at pc 0x00:
  - `instr_data`=0x3C, `instr_addr`=0x00, `instr_valid` at cycle 2;
  - one `pc_step`; next fetch at 0x01.
- Memory with 3-cycle ack latency, `instr_ready` held low 4 cycles:
  - `instr_valid` holds and `instr_data` stays stable;
  - no second `mem_req` until the handshake completes.
- `redirect`=1 with `redirect_addr`=0xA0 in the same cycle as `mem_ack`:
  - data discarded, no `pc_step`;
  - `pc_set`=1 with `pc_set_val`=0xA0; next `mem_addr`=0xA0.
- Counter at 0xFF, fetch completes:
  - `pc_step` is issued; the next `mem_addr`=0x00.
- `mem_ack` never asserted with `TIMEOUT`=15:
  - `err`=1 after 15 `FETCH` cycles and `mem_req` drops;
  - `redirect`/`run` are ignored until reset.
- `reset_n` pulsed low mid-`VALID`:
  - all outputs go to 0 immediately (async);
  - state returns to `IDLE`.
